// File: rtl/tmds_decoder.sv
// TMDS receive decoder: bit-slip alignment against DVI control tokens,
// lock/timeout supervision, and 10b->8b data decode for one channel.
module tmds_decoder #(
  parameter int LOCK_COUNT = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [9:0] raw_in,
  output logic [7:0] data_out,
  output logic [1:0] control_out,
  output logic       de_out,
  output logic       locked_out,
  output logic [3:0] offset_out
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int TO_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  // {hit, value[1:0]} for the four DVI control tokens
  function automatic logic [2:0] classify(input logic [9:0] w);
    logic [2:0] r;
    case (w)
      10'b1101010100: r = 3'b100;
      10'b0010101011: r = 3'b101;
      10'b0101010100: r = 3'b110;
      10'b1010101011: r = 3'b111;
      default:        r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] q);
    logic [7:0] dp;
    logic [7:0] d;
    dp   = q[9] ? ~q[7:0] : q[7:0];
    d[0] = dp[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (dp[i] ^ dp[i-1]) : ~(dp[i] ^ dp[i-1]);
    end
    return d;
  endfunction

  state_t           state_q, state_d;
  logic [9:0]       prev_q, prev_d;
  logic [3:0]       offset_q, offset_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [TO_W-1:0]  timeout_q, timeout_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       control_q, control_d;
  logic             de_q, de_d;
  logic             locked_q, locked_d;

  // Highest window (k=9) reaches raw_in[8], so raw_in[9] only feeds prev_q.
  logic [18:0] concat;
  logic [9:0]  win [10];
  logic [2:0]  win_cls [10];
  logic [9:0]  win_hit;

  assign concat = {raw_in[8:0], prev_q};

  for (genvar gi = 0; gi < 10; gi++) begin : g_win
    assign win[gi]     = concat[gi+9:gi];
    assign win_cls[gi] = classify(win[gi]);
    assign win_hit[gi] = win_cls[gi][2];
  end

  logic [9:0]       sel_win;
  logic [2:0]       sel_cls;
  logic [3:0]       hunt_off;
  logic [RUN_W-1:0] run_inc;
  logic             run_done;

  always_comb begin
    sel_win  = '0;
    hunt_off = '0;
    for (int i = 0; i < 10; i++) begin
      if (offset_q == 4'(i)) sel_win = win[i];
    end
    for (int i = 9; i >= 0; i--) begin
      if (win_hit[i]) hunt_off = 4'(i);
    end
    sel_cls  = classify(sel_win);
    run_inc  = run_q + RUN_W'(1);
    run_done = sel_cls[2] && (run_inc == RUN_W'(LOCK_COUNT));
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = raw_in;
    offset_d  = offset_q;
    run_d     = run_q;
    timeout_d = timeout_q;
    data_d    = data_q;
    control_d = control_q;
    de_d      = 1'b0;
    locked_d  = 1'b0;

    case (state_q)
      HUNT: begin
        if (|win_hit) begin
          offset_d = hunt_off;
          run_d    = RUN_W'(1);
          state_d  = VERIFY;
        end
      end
      VERIFY: begin
        if (!sel_cls[2]) begin
          state_d = HUNT;
          run_d   = '0;
        end else if (run_done) begin
          state_d   = LOCKED;
          run_d     = '0;
          timeout_d = '0;
        end else begin
          run_d = run_inc;
        end
      end
      LOCKED: begin
        run_d = (sel_cls[2] && !run_done) ? run_inc : '0;
        if (run_done) begin
          timeout_d = '0;
        end else if (timeout_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = HUNT;
          timeout_d = '0;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end
      default: state_d = HUNT;
    endcase

    // Outputs track the state being entered so locked_out rises with the lock edge.
    if (state_d == LOCKED) begin
      locked_d = 1'b1;
      if (sel_cls[2]) begin
        control_d = sel_cls[1:0];
      end else begin
        de_d   = 1'b1;
        data_d = decode(sel_win);
      end
    end else begin
      data_d    = '0;
      control_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= HUNT;
      prev_q    <= '0;
      offset_q  <= '0;
      run_q     <= '0;
      timeout_q <= '0;
      data_q    <= '0;
      control_q <= '0;
      de_q      <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      offset_q  <= offset_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
      data_q    <= data_d;
      control_q <= control_d;
      de_q      <= de_d;
      locked_q  <= locked_d;
    end
  end

  assign data_out    = data_q;
  assign control_out = control_q;
  assign de_out      = de_q;
  assign locked_out  = locked_q;
  assign offset_out  = offset_q;

endmodule
